// File: rtl/sprite_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_mux_pkg
//  Description : Shared definitions for the sprite engine: register offsets,
//                CTRL bit positions, fetch FSM states and sprite width.
//  Revision    : 1.0 - initial release
// ============================================================================
package sprite_mux_pkg;

  localparam int SPRITE_W = 8;

  // Per-sprite register offsets within each 3-register group
  localparam int OFS_X    = 0;
  localparam int OFS_Y    = 1;
  localparam int OFS_CTRL = 2;

  // CTRL = {en, hflip, color[2:0], bitmap[2:0]}
  localparam int CTRL_EN         = 7;
  localparam int CTRL_HFLIP      = 6;
  localparam int CTRL_COLOR_LSB  = 3;
  localparam int CTRL_BITMAP_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_REQ   = 3'd2,
    ST_LATCH = 3'd3,
    ST_DONE  = 3'd4
  } fetch_state_t;

  function automatic logic [SPRITE_W-1:0] bit_reverse(input logic [SPRITE_W-1:0] d);
    logic [SPRITE_W-1:0] r;
    for (int b = 0; b < SPRITE_W; b++) r[b] = d[SPRITE_W-1-b];
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_mux_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_mux_engine_if
//  Description : CPU register bus of the sprite engine.
//                master = CPU side, slave = engine side.
//                reg_addr/reg_wdata/reg_we/reg_re : CPU -> engine
//                reg_rdata                        : engine -> CPU (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
interface sprite_mux_engine_if #(
  parameter int REG_AW = 6
);
  logic [REG_AW-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;

  modport master (output reg_addr, reg_wdata, reg_we, reg_re, input  reg_rdata);
  modport slave  (input  reg_addr, reg_wdata, reg_we, reg_re, output reg_rdata);
endinterface
`default_nettype wire

// File: rtl/sprite_channel.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_channel
//  Description : One sprite channel: line buffer (optionally mirrored on load),
//                X compare and 8-pixel MSB-first shifter.
//                clk/reset   : clock, async active-high reset
//                hpos        : beam column
//                x_pos       : sprite X register (live)
//                line_load   : latch line_data into the line buffer
//                line_clr    : clear the line buffer
//                hflip       : mirror line_data on load
//                opaque      : current column pixel of this sprite (comb.)
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_channel
  import sprite_mux_pkg::*;
(
  input  wire logic                clk,
  input  wire logic                reset,
  input  wire logic [8:0]          hpos,
  input  wire logic [7:0]          x_pos,
  input  wire logic                line_load,
  input  wire logic                line_clr,
  input  wire logic                hflip,
  input  wire logic [SPRITE_W-1:0] line_data,
  output logic                     opaque
);

  logic [SPRITE_W-1:0] r_linebuf;
  logic [SPRITE_W-1:0] r_shift;
  logic [3:0]          r_cnt;
  logic                w_start;
  logic                w_pix;

  // Zero-extended compare can only match on columns 0..255
  assign w_start = (hpos == {1'b0, x_pos});

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_linebuf <= '0;
    else if (line_clr)  r_linebuf <= '0;
    else if (line_load) r_linebuf <= hflip ? bit_reverse(line_data) : line_data;
  end

  // The start column pixel comes straight from the line buffer; the shifter
  // holds the remaining 7 pixels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_start) begin
      r_shift <= {r_linebuf[SPRITE_W-2:0], 1'b0};
      r_cnt   <= 4'(SPRITE_W - 1);
    end else if (r_cnt != 4'd0) begin
      r_shift <= {r_shift[SPRITE_W-2:0], 1'b0};
      r_cnt   <= r_cnt - 4'd1;
    end
  end

  always_comb begin
    w_pix = 1'b0;
    if (w_start)             w_pix = r_linebuf[SPRITE_W-1];
    else if (r_cnt != 4'd0)  w_pix = r_shift[SPRITE_W-1];
  end

  // Pixels past column 255 are dropped
  assign opaque = w_pix & ~hpos[8];

endmodule
`default_nettype wire

// File: rtl/sprite_mux_engine.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_mux_engine
//  Description : N-channel sprite engine. Holds X/Y/CTRL registers, prefetches
//                one bitmap row per sprite during hblank, muxes pixels with
//                lowest-index priority and latches sticky collision flags.
//                clk/reset       : clock, async active-high reset
//                hpos/vpos       : beam position
//                display_on      : active video
//                pf_gfx          : playfield pixel (collision only)
//                bus             : CPU register bus (slave)
//                rom_addr/rom_data : bitmap ROM, data one cycle after address
//                pixel_on/pixel_rgb : registered sprite pixel
//                collide_any     : OR of both collision registers
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_mux_engine
  import sprite_mux_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_H    = 16,
  parameter int REG_AW      = 6,
  parameter int FETCH_START = 256
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic [8:0]    hpos,
  input  wire logic [8:0]    vpos,
  input  wire logic          display_on,
  input  wire logic          pf_gfx,
  sprite_mux_engine_if.slave bus,
  output logic [6:0]         rom_addr,
  input  wire logic [7:0]    rom_data,
  output logic               pixel_on,
  output logic [2:0]         pixel_rgb,
  output logic               collide_any
);

  localparam logic [REG_AW-1:0] c_addr_ss = REG_AW'(3 * NUM_SPRITES);
  localparam logic [REG_AW-1:0] c_addr_sp = REG_AW'(3 * NUM_SPRITES + 1);
  localparam int                c_rd_w    = (NUM_SPRITES < 8) ? NUM_SPRITES : 8;

  logic [7:0]             r_x    [NUM_SPRITES];
  logic [7:0]             r_y    [NUM_SPRITES];
  logic [7:0]             r_ctrl [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] r_ss, r_sp;
  logic [NUM_SPRITES-1:0] w_chan_opq, w_opaque;
  logic                   w_multi, w_ss_clr, w_sp_clr;
  logic [2:0]             w_pix_rgb;

  fetch_state_t r_state, w_state_n;
  logic [4:0]   r_idx, w_idx_n;
  logic [6:0]   w_rom_addr_n;
  logic         w_load, w_clr, w_last, w_hit;
  logic [7:0]   w_cur_y;
  logic         w_cur_en;
  logic [2:0]   w_cur_bitmap;
  logic [8:0]   w_row;

  // ---------------- register file ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_x[i]    <= '0;
        r_y[i]    <= '0;
        r_ctrl[i] <= '0;
      end
    end else if (bus.reg_we) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        if (bus.reg_addr == REG_AW'(3 * i + OFS_X))    r_x[i]    <= bus.reg_wdata;
        if (bus.reg_addr == REG_AW'(3 * i + OFS_Y))    r_y[i]    <= bus.reg_wdata;
        if (bus.reg_addr == REG_AW'(3 * i + OFS_CTRL)) r_ctrl[i] <= bus.reg_wdata;
      end
    end
  end

  always_comb begin
    bus.reg_rdata = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (bus.reg_addr == REG_AW'(3 * i + OFS_X))    bus.reg_rdata = r_x[i];
      if (bus.reg_addr == REG_AW'(3 * i + OFS_Y))    bus.reg_rdata = r_y[i];
      if (bus.reg_addr == REG_AW'(3 * i + OFS_CTRL)) bus.reg_rdata = r_ctrl[i];
    end
    if (bus.reg_addr == c_addr_ss) bus.reg_rdata = 8'(r_ss[c_rd_w-1:0]);
    if (bus.reg_addr == c_addr_sp) bus.reg_rdata = 8'(r_sp[c_rd_w-1:0]);
  end

  // ---------------- fetch FSM ----------------
  always_comb begin
    w_cur_y      = '0;
    w_cur_en     = 1'b0;
    w_cur_bitmap = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      if (r_idx == 5'(i)) begin
        w_cur_y      = r_y[i];
        w_cur_en     = r_ctrl[i][CTRL_EN];
        w_cur_bitmap = r_ctrl[i][CTRL_BITMAP_LSB +: 3];
      end
    end
  end

  // Row of the sprite on the upcoming line; unsigned wrap makes "above the
  // sprite" a large value that fails the height test.
  assign w_row  = 9'(vpos + 9'd1 - {1'b0, w_cur_y});
  assign w_hit  = w_cur_en && (w_row < 9'(SPRITE_H));
  assign w_last = (r_idx == 5'(NUM_SPRITES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      rom_addr <= '0;
    end else begin
      r_state  <= w_state_n;
      r_idx    <= w_idx_n;
      rom_addr <= w_rom_addr_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_idx_n      = r_idx;
    w_rom_addr_n = rom_addr;
    w_load       = 1'b0;
    w_clr        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (hpos == 9'(FETCH_START)) begin
          w_state_n = ST_CHECK;
          w_idx_n   = '0;
        end
      end
      ST_CHECK: begin
        if (w_hit) begin
          w_rom_addr_n = {w_cur_bitmap, w_row[3:0]};
          w_state_n    = ST_REQ;
        end else begin
          w_clr = 1'b1;
          if (w_last) w_state_n = ST_DONE;
          else begin
            w_idx_n   = r_idx + 5'd1;
            w_state_n = ST_CHECK;
          end
        end
      end
      ST_REQ:   w_state_n = ST_LATCH;
      ST_LATCH: begin
        w_load = 1'b1;
        if (w_last) w_state_n = ST_DONE;
        else begin
          w_idx_n   = r_idx + 5'd1;
          w_state_n = ST_CHECK;
        end
      end
      ST_DONE: if (hpos < 9'(FETCH_START)) w_state_n = ST_IDLE;
      default: w_state_n = ST_IDLE;
    endcase
  end

  // ---------------- channels ----------------
  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_chan
    sprite_channel u_chan (
      .clk       (clk),
      .reset     (reset),
      .hpos      (hpos),
      .x_pos     (r_x[g]),
      .line_load (w_load && (r_idx == 5'(g))),
      .line_clr  (w_clr  && (r_idx == 5'(g))),
      .hflip     (r_ctrl[g][CTRL_HFLIP]),
      .line_data (rom_data),
      .opaque    (w_chan_opq[g])
    );
  end

  assign w_opaque = display_on ? w_chan_opq : '0;

  // ---------------- priority mux / pixel output ----------------
  always_comb begin
    w_pix_rgb = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--)
      if (w_opaque[i]) w_pix_rgb = r_ctrl[i][CTRL_COLOR_LSB +: 3];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_on  <= 1'b0;
      pixel_rgb <= '0;
    end else begin
      pixel_on  <= |w_opaque;
      pixel_rgb <= w_pix_rgb;
    end
  end

  // ---------------- collisions ----------------
  // More than one bit set <=> clearing the lowest set bit leaves something.
  assign w_multi  = (w_opaque & (w_opaque - NUM_SPRITES'(1))) != '0;
  assign w_ss_clr = bus.reg_re && (bus.reg_addr == c_addr_ss);
  assign w_sp_clr = bus.reg_re && (bus.reg_addr == c_addr_sp);

  // Clear is applied first so a same-cycle set survives
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ss <= '0;
      r_sp <= '0;
    end else begin
      r_ss <= (w_ss_clr ? '0 : r_ss) | (w_multi ? w_opaque : '0);
      r_sp <= (w_sp_clr ? '0 : r_sp) | (pf_gfx  ? w_opaque : '0);
    end
  end

  assign collide_any = (|r_ss) | (|r_sp);

endmodule
`default_nettype wire

// File: tb/tb_sprite_mux_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_mux_engine
//  Description : Self-checking bench for sprite_mux_engine. Drives whole
//                scanlines and compares every output pixel and collision flag
//                against a per-column reference model derived from the sprite
//                rules (row = v - Y, column = h - X, lowest index wins).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_mux_engine;

  localparam int N        = 4;
  localparam int H        = 16;
  localparam int AW       = 6;
  localparam int LINE_LEN = 320;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] hpos = '0;
  logic [8:0] vpos = '0;
  logic       display_on = 1'b0;
  logic       pf_gfx = 1'b0;
  logic [6:0] rom_addr;
  logic [7:0] rom_data;
  logic       pixel_on;
  logic [2:0] pixel_rgb;
  logic       collide_any;

  sprite_mux_engine_if #(.REG_AW(AW)) bus ();

  sprite_mux_engine #(
    .NUM_SPRITES (N),
    .SPRITE_H    (H),
    .REG_AW      (AW),
    .FETCH_START (256)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hpos        (hpos),
    .vpos        (vpos),
    .display_on  (display_on),
    .pf_gfx      (pf_gfx),
    .bus         (bus),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .pixel_on    (pixel_on),
    .pixel_rgb   (pixel_rgb),
    .collide_any (collide_any)
  );

  always #5 clk = ~clk;

  // Synchronous bitmap ROM
  logic [7:0] rom [128];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Reference model state
  logic [7:0]   m_x [N];
  logic [7:0]   m_y [N];
  logic [7:0]   m_ctrl [N];
  logic [N-1:0] m_ss, m_sp;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [7:0] rev8(input logic [7:0] d);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = d[7-b];
    return r;
  endfunction

  // Is sprite i opaque at beam (v, h)?
  function automatic bit ref_opaque(input int i, input int v, input int h);
    int row, col;
    logic [7:0] d;
    if (m_ctrl[i][7] !== 1'b1) return 1'b0;
    row = (v - int'(m_y[i])) & 511;
    col = h - int'(m_x[i]);
    if (row >= H || h > 255 || col < 0 || col > 7) return 1'b0;
    d = rom[int'(m_ctrl[i][2:0]) * 16 + row];
    if (m_ctrl[i][6]) d = rev8(d);
    return d[7-col];
  endfunction

  task automatic idle_bus();
    hpos = '0; display_on = 1'b0; pf_gfx = 1'b0;
  endtask

  task automatic write_reg(input int a, input logic [7:0] d);
    idle_bus();
    bus.reg_addr = AW'(a); bus.reg_wdata = d; bus.reg_we = 1'b1;
    @(posedge clk); #1;
    bus.reg_we = 1'b0;
    if (a < 3 * N) begin
      case (a % 3)
        0:       m_x[a/3]    = d;
        1:       m_y[a/3]    = d;
        default: m_ctrl[a/3] = d;
      endcase
    end
  endtask

  task automatic clear_reg(input int a);
    idle_bus();
    bus.reg_addr = AW'(a); bus.reg_re = 1'b1;
    @(posedge clk); #1;
    bus.reg_re = 1'b0;
    if (a == 3 * N)     m_ss = '0;
    if (a == 3 * N + 1) m_sp = '0;
  endtask

  task automatic check_reg(input int a, input logic [7:0] exp, input string name);
    bus.reg_addr = AW'(a); bus.reg_re = 1'b0; #1;
    n_vec++;
    if (bus.reg_rdata !== exp) begin
      n_err++;
      $display("FAIL %s: reg[%0d] read 0x%02h, expected 0x%02h", name, a, bus.reg_rdata, exp);
    end
  endtask

  // One scanline. pf_mode: 0 low, 1 high, 2 random. re_at: column at which a
  // clear-on-read of the SS register is issued (-1 = none).
  task automatic run_line(input int v, input bit disp, input int pf_mode,
                          input int re_at, output int npix);
    logic [N-1:0] opq;
    bit           exp_on;
    logic [2:0]   exp_rgb;
    npix = 0;
    for (int h = 0; h < LINE_LEN; h++) begin
      hpos       = 9'(h);
      vpos       = 9'(v);
      display_on = disp && (h < 256) && (v < 256);
      pf_gfx     = (pf_mode == 2) ? 1'($urandom_range(0, 1)) : (pf_mode == 1);
      bus.reg_re = (h == re_at);
      if (h == re_at) bus.reg_addr = AW'(3 * N);
      opq = '0;
      if (display_on) for (int i = 0; i < N; i++) opq[i] = ref_opaque(i, v, h);
      exp_on  = |opq;
      exp_rgb = '0;
      for (int i = N - 1; i >= 0; i--) if (opq[i]) exp_rgb = m_ctrl[i][5:3];
      if (h == re_at) m_ss = '0;
      if ($countones(opq) >= 2) m_ss |= opq;
      if (pf_gfx) m_sp |= opq;
      @(posedge clk); #1;
      bus.reg_re = 1'b0;
      n_vec++;
      if (pixel_on !== exp_on || pixel_rgb !== exp_rgb) begin
        n_err++;
        $display("FAIL pixel v=%0d h=%0d: got on=%b rgb=%0d, expected on=%b rgb=%0d",
                 v, h, pixel_on, pixel_rgb, exp_on, exp_rgb);
      end
      n_vec++;
      if (collide_any !== ((m_ss != '0) || (m_sp != '0))) begin
        n_err++;
        $display("FAIL collide_any v=%0d h=%0d: got %b, expected %b",
                 v, h, collide_any, (m_ss != '0) || (m_sp != '0));
      end
      if (pixel_on === 1'b1) npix++;
    end
  endtask

  task automatic check_count(input int got, input int exp, input string name);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: %0d pixels on the line, expected %0d", name, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int np;
    reset = 1'b1; idle_bus();
    repeat (2) @(posedge clk); #1;
    n_vec++;
    if ({pixel_on, pixel_rgb, collide_any, rom_addr} !== 12'd0) begin
      n_err++;
      $display("FAIL reset_hold: outputs 0x%03h, expected 0x000",
               {pixel_on, pixel_rgb, collide_any, rom_addr});
    end
    reset = 1'b0;
    for (int k = 0; k < 128; k++) rom[k] = 8'($urandom);
    write_reg(0, 8'd5); write_reg(1, 8'd0); write_reg(2, 8'h95);
    // Walk into the fetch window: hpos 256 -> CHECK, 257 -> REQ, 258 -> LATCH
    for (int h = 250; h < 259; h++) begin
      hpos = 9'(h); vpos = '0;
      @(posedge clk); #1;
    end
    n_vec++;
    if (rom_addr !== 7'h51) begin
      n_err++;
      $display("FAIL fetch_addr: rom_addr 0x%02h, expected 0x51", rom_addr);
    end
    reset = 1'b1; #1;
    n_vec++;
    if ({pixel_on, pixel_rgb, collide_any, rom_addr} !== 12'd0) begin
      n_err++;
      $display("FAIL reset_async: outputs 0x%03h, expected 0x000",
               {pixel_on, pixel_rgb, collide_any, rom_addr});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin m_x[i] = '0; m_y[i] = '0; m_ctrl[i] = '0; end
    m_ss = '0; m_sp = '0;
    for (int a = 0; a < (1 << AW); a++) check_reg(a, 8'h00, "reset_read");
    for (int v = 0; v < 3; v++) begin
      run_line(v, 1'b1, 2, -1, np);
      check_count(np, 0, "reset_no_pixels");
    end
  endtask

  task automatic test_single();
    int np;
    rom[0] = 8'h81;
    write_reg(0, 8'd10); write_reg(1, 8'd20); write_reg(2, 8'h90);
    run_line(19, 1'b0, 0, -1, np);
    run_line(20, 1'b1, 0, -1, np);
    check_count(np, 2, "single_0x81");
    run_line(21, 1'b1, 0, -1, np);
  endtask

  task automatic test_hflip_edge();
    int np;
    rom[0] = 8'hF0;
    write_reg(2, 8'hD0);
    run_line(19, 1'b0, 0, -1, np);
    run_line(20, 1'b1, 0, -1, np);
    check_count(np, 4, "hflip_0xF0");
    rom[0] = 8'hFF;
    write_reg(0, 8'd252); write_reg(2, 8'h90);
    run_line(19, 1'b0, 0, -1, np);
    run_line(20, 1'b1, 0, -1, np);
    check_count(np, 4, "right_edge");
  endtask

  task automatic test_overlap();
    int np;
    rom[0] = 8'hFF; rom[16] = 8'hFF; rom[1] = 8'h10; rom[17] = 8'h10;
    write_reg(0, 8'd40); write_reg(1, 8'd50); write_reg(2, 8'h90);
    write_reg(3, 8'd40); write_reg(4, 8'd50); write_reg(5, 8'hA9);
    clear_reg(3 * N); clear_reg(3 * N + 1);
    run_line(49, 1'b0, 0, -1, np);
    run_line(50, 1'b1, 0, -1, np);
    check_reg(3 * N, 8'h03, "ss_overlap");
    clear_reg(3 * N);
    check_reg(3 * N, 8'h00, "ss_cleared");
    // Row 1 overlaps only at column 43, the same cycle as the clear
    run_line(51, 1'b1, 0, 43, np);
    check_reg(3 * N, 8'h03, "ss_set_wins");
  endtask

  task automatic test_playfield();
    int np;
    rom[32] = 8'h3C;
    write_reg(2, 8'h00); write_reg(5, 8'h00);
    write_reg(6, 8'd100); write_reg(7, 8'd60); write_reg(8, 8'h9A);
    clear_reg(3 * N); clear_reg(3 * N + 1);
    run_line(59, 1'b0, 0, -1, np);
    run_line(60, 1'b1, 1, -1, np);
    check_count(np, 4, "pf_sprite2");
    check_reg(3 * N + 1, 8'h04, "sp_sprite2");
    check_reg(3 * N, 8'h00, "ss_single");
    n_vec++;
    if (collide_any !== 1'b1) begin
      n_err++;
      $display("FAIL collide_any_pf: got %b, expected 1", collide_any);
    end
  endtask

  task automatic test_random();
    int np, v0, xb;
    for (int it = 0; it < 5; it++) begin
      v0 = $urandom_range(20, 250);
      xb = $urandom_range(0, 250);
      for (int k = 0; k < 128; k++) rom[k] = 8'($urandom);
      for (int i = 0; i < N; i++) begin
        write_reg(3 * i,     8'(xb + $urandom_range(0, 5)));
        write_reg(3 * i + 1, 8'(v0 - $urandom_range(0, 12)));
        write_reg(3 * i + 2, ($urandom_range(0, 3) != 0) ? (8'($urandom) | 8'h80)
                                                         : (8'($urandom) & 8'h7F));
      end
      clear_reg(3 * N); clear_reg(3 * N + 1);
      run_line(v0 - 1, 1'b0, 2, -1, np);
      for (int l = 0; l < 3; l++) run_line(v0 + l, 1'b1, 2, -1, np);
      check_reg(3 * N,     8'(m_ss), "rand_ss");
      check_reg(3 * N + 1, 8'(m_sp), "rand_sp");
      for (int i = 0; i < N; i++) begin
        check_reg(3 * i,     m_x[i],    "rand_x");
        check_reg(3 * i + 1, m_y[i],    "rand_y");
        check_reg(3 * i + 2, m_ctrl[i], "rand_ctrl");
      end
    end
  endtask

  task automatic test_bottom_edge();
    int np;
    for (int k = 0; k < 16; k++) rom[k] = 8'hFF;
    for (int i = 1; i < N; i++) write_reg(3 * i + 2, 8'h00);
    write_reg(0, 8'd30); write_reg(1, 8'd250); write_reg(2, 8'h90);
    run_line(249, 1'b0, 0, -1, np);
    for (int v = 250; v < 258; v++) begin
      run_line(v, 1'b1, 0, -1, np);
      check_count(np, (v < 256) ? 8 : 0, "bottom_rows");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.reg_addr = '0; bus.reg_wdata = '0; bus.reg_we = 1'b0; bus.reg_re = 1'b0;
    m_ss = '0; m_sp = '0;
    for (int i = 0; i < N; i++) begin m_x[i] = '0; m_y[i] = '0; m_ctrl[i] = '0; end
    test_reset();
    test_single();
    test_hflip_edge();
    test_overlap();
    test_playfield();
    test_random();
    test_bottom_edge();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sprite_mux_engine.md
Name: sprite_mux_engine

Overview:
- Generalised N-channel hardware sprite engine for the 8-bit CPU racing and arcade designs. It replaces per-game hand-wired pairs of sprite renderers.
- Holds CPU-writable per-sprite X/Y/CTRL registers.
- During horizontal blank it prefetches one bitmap row per sprite from a shared synchronous bitmap ROM.
- During the active line it shifts pixels out with fixed priority (lowest index wins), and latches sticky sprite-sprite and sprite-playfield collision flags that the CPU can read.

Parameters:
- NUM_SPRITES, 4, number of sprite channels (1..16)
- SPRITE_H, 16, bitmap rows per sprite (power of two, max 16)
- REG_AW, 6, CPU register address width (must satisfy 3*NUM_SPRITES+2 <= 2**REG_AW)
- FETCH_START, 256, hpos at which the row prefetch begins

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- hpos  in  9  beam horizontal position from hvsync_generator
- vpos  in  9  beam vertical position
- display_on  in  1  active-video flag
- pf_gfx  in  1  playfield pixel, used for collision only
- reg_addr  in  REG_AW  CPU register index
- reg_wdata  in  8  CPU write data
- reg_we  in  1  CPU write strobe
- reg_re  in  1  CPU read strobe (clear-on-read side effect)
- reg_rdata  out  8  combinational read data
- rom_addr  out  7  {bitmap_sel[2:0], row[3:0]} to the bitmap ROM
- rom_data  in  8  ROM data, valid one cycle after rom_addr
- pixel_on  out  1  any sprite pixel opaque
- pixel_rgb  out  3  colour of the winning sprite
- collide_any  out  1  OR of both collision registers

Behaviour:
- Register map:
  - 3i+0 = X[i]
  - 3i+1 = Y[i]
  - 3i+2 = CTRL[i] = {en, hflip, color[2:0], bitmap[2:0]}
  - 3N = SS collision: bit i set when sprite i overlapped any other opaque sprite
  - 3N+1 = SP collision: bit i set when sprite i overlapped pf_gfx
  - Bits >= N and unmapped addresses read 0; writes to the collision registers are ignored.
- Reset (async): all X/Y/CTRL = 0, so all sprites are disabled. Line buffers = 0, collision registers = 0, pixel_on/pixel_rgb/collide_any = 0, rom_addr = 0, FSM = IDLE.
- Fetch FSM states: IDLE, CHECK, REQ, LATCH, DONE.
  - IDLE -> CHECK when hpos == FETCH_START, with index i = 0.
  - CHECK computes row = (vpos+1) - {0,Y[i]} (9-bit, unsigned wrap).
    - If en and row < SPRITE_H: drive rom_addr = {bitmap, row[3:0]} and go to REQ.
    - Otherwise clear linebuf[i] and advance.
  - REQ waits one cycle for the ROM.
  - LATCH writes rom_data into linebuf[i], bit-reversed when hflip = 1, then advances.
  - Advance: i++; when i == NUM_SPRITES go to DONE.
  - DONE -> IDLE when hpos < FETCH_START, i.e. after the wrap.
- Worst case is 3 cycles per sprite. 16 sprites take 48 cycles, which fits the blank interval (hpos 256..308).
- Display: for each channel, when hpos == {0,X[i]} and hpos < 256, the shifter loads linebuf[i] and emits MSB first for 8 clocks. Pixels beyond column 255 are suppressed.
- Outputs are registered. The pixel for column h appears on the cycle after hpos == h, gated by display_on.
- Priority: the lowest-index opaque sprite drives pixel_rgb. pixel_rgb = 0 when pixel_on = 0.
- Collision: when two or more sprites are opaque, set the SS bit for each of them. When sprite i is opaque and pf_gfx = 1, set SP bit i.
  - reg_re at address 3N or 3N+1 clears that register on the next edge.
  - A set and a clear in the same cycle leaves the bit set.
  - Collision registers are not cleared at frame start.
- Register writes take effect immediately for position compares. A bitmap row already latched is not re-fetched until the next blank.
- Async reset during a fetch aborts to IDLE. The next line's fetch starts normally.

Decomposition:
- Shared package sprite_mux_pkg holds:
  - register offsets (OFS_X, OFS_Y, OFS_CTRL)
  - CTRL bit positions
  - FSM state encoding
  - SPRITE_W = 8
- One sub-module, sprite_channel, is instantiated NUM_SPRITES times. It contains the line buffer, hflip latch, X compare, shifter, and opaque output.
- The top level owns the register file, fetch FSM, priority mux, and collision logic.

Test Plan:
- Reset: assert reset mid-line, then release -> all outputs 0; reg_rdata = 0 for every address; no pixel output for a full frame.
- Sprite 0 X=10, Y=20, CTRL=0x90 (en, color 010, bitmap 0); ROM row 0 = 0x81 -> on vpos 20, pixel_on = 1 on the cycles after hpos 10 and hpos 17 only; pixel_rgb = 3'b010.
- Same setup with hflip and ROM = 0xF0 -> pixels at hpos 14..17 only. Sprite with X=252 -> only 4 pixels emitted, none on the hpos >= 256 cycles.
- Sprites 0 and 1 at an identical position with different colours -> pixel_rgb = sprite 0 colour; reg 3N reads 0x03. reg_re at 3N -> next read is 0x00. Overlap coinciding with the reg_re cycle -> bit stays 1.
- pf_gfx held high under sprite 2 -> reg 3N+1 = 0x04; collide_any = 1.
- NUM_SPRITES = 16, all enabled on the same line -> every LATCH completes by hpos 304. Sprite Y = 250, SPRITE_H = 16 -> rows 0..5 drawn on vpos 250..255; vpos 256+ rows suppressed by display_on.
